bb_slave_port: RTL and testbench
================================

BB_SLAVE_PORT -- requirements
Module: bb_slave_port

Interface
REQ-001 Parameter DEVICE_ID, default 4'h1, is the slave select value compared against address bits [15:12].
REQ-002 Parameter SPLIT_DELAY, default 4, is the number of read-wait cycles after which split is raised.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 mode  in  1  transaction type from master: 1=write, 0=read.
REQ-006 wr_bus  in  1  serial address/write-data bit, MSB first.
REQ-007 master_valid  in  1  wr_bus bit valid.
REQ-008 slave_ready  out  1  slave accepts wr_bus bit this cycle.
REQ-009 ack  out  1  address-select acknowledge.
REQ-010 rd_bus  out  1  serial read-data bit, MSB first.
REQ-011 slave_valid  out  1  rd_bus bit valid.
REQ-012 master_ready  in  1  master accepts rd_bus bit.
REQ-013 split  out  1  read split: master releases the data phase while high.
REQ-014 mem_addr  out  12  local address, address bits [11:0].
REQ-015 mem_wdata  out  8  local write data.
REQ-016 mem_wen  out  1  one-cycle local write strobe.
REQ-017 mem_ren  out  1  one-cycle local read strobe.
REQ-018 mem_rdata  in  8  local read data.
REQ-019 mem_rvalid  in  1  mem_rdata valid, one-cycle pulse.

Function
REQ-020 States SHALL be IDLE, ADDR, IGNORE, WDATA, MEM_WR, RD_REQ, RD_WAIT, RD_DATA.
REQ-021 A bit transfer SHALL be defined as master_valid & slave_ready on a rising edge.
REQ-022 slave_ready SHALL be 1 in IDLE, ADDR, WDATA and IGNORE, and 0 in all other states.
REQ-023 IDLE: the first transfer SHALL capture addr[15] and mode, set bit count to 1, and enter ADDR.
REQ-024 ADDR: transfers SHALL shift address bits MSB first into a 16-bit register; a 4-bit count SHALL track the bit index.
REQ-025 On the transfer of bit index 3, the slave SHALL register id_match = (addr[15:12] == DEVICE_ID).
REQ-026 ack SHALL equal (state==ADDR) & (count is 4 or 5) & id_match, and SHALL be 0 otherwise.
REQ-027 On the transfer of bit index 5 without id_match, the next state SHALL be IGNORE.
REQ-028 IGNORE SHALL return to IDLE on the first cycle with master_valid==0.
REQ-029 On the transfer of bit index 15 (count wraps to 0), the next state SHALL be WDATA if mode==1, else RD_REQ.
REQ-030 WDATA SHALL collect 8 bits MSB first, then enter MEM_WR.
REQ-031 MEM_WR SHALL assert mem_wen for exactly 1 cycle with mem_addr=addr[11:0] and mem_wdata, then enter IDLE.
REQ-032 RD_REQ SHALL assert mem_ren for 1 cycle, clear the wait counter, and enter RD_WAIT.
REQ-033 RD_WAIT: mem_rvalid SHALL latch mem_rdata, clear split, and enter RD_DATA.
REQ-034 RD_WAIT: split SHALL be 1 while the wait counter >= SPLIT_DELAY, and the counter SHALL saturate.
REQ-035 mem_rvalid in the same cycle the counter reaches SPLIT_DELAY SHALL take priority, so split is not raised.
REQ-036 RD_DATA: slave_valid SHALL be 1, and rd_bus SHALL be rdata[7-count].
REQ-037 RD_DATA: each master_ready & slave_valid SHALL advance count; after the 8th bit the next state SHALL be IDLE.
REQ-038 rd_bus SHALL be 0 outside RD_DATA.
REQ-039 mem_addr SHALL hold its value between transactions.
REQ-040 mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-041 master_valid==0 inside ADDR or WDATA SHALL stall the slave, with no count change and no timeout.

Reset
REQ-042 With rstn low, the slave SHALL be in IDLE, all registers 0, all outputs 0 except slave_ready=1.
REQ-043 Reset mid-transaction SHALL abort the transaction, with no mem_wen or mem_ren pulse afterwards.

Verification
REQ-044 Write, addr 16'h1234, data 8'hA5, DEVICE_ID=1 -> ack high at bit indices 4-5, then mem_wen for 1 cycle with mem_addr=12'h234 and mem_wdata=8'hA5, then IDLE.
REQ-045 Read, addr 16'h1010, mem_rvalid 2 cycles after mem_ren with data 8'h3C -> split never high, rd_bus serialises 0,0,1,1,1,1,0,0.
REQ-046 Read with mem_rvalid 10 cycles after mem_ren -> split high from wait cycle 4 until mem_rvalid, then 8 correct bits.
REQ-047 Address 16'h2000 with DEVICE_ID=1 -> ack stays 0, the slave enters IGNORE, returns to IDLE when master_valid drops, no mem strobes.
REQ-048 master_valid toggled 1/0 every cycle during a write -> data still assembled correctly.
REQ-049 rstn pulsed after address bit 10 of a write -> all outputs at reset values, no mem_wen, next transaction completes normally.

Source files
------------

// File: rtl/bb_slave_port.sv
// Bit-serial bus slave: address/write data arrive serially on wr_bus, read data leave on rd_bus.
// Decodes a 16-bit address and bridges single-byte reads and writes onto a local memory port.
module bb_slave_port #(
    parameter logic [3:0] DEVICE_ID   = 4'h1,
    parameter int         SPLIT_DELAY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mode,
    input  logic        wr_bus,
    input  logic        master_valid,
    output logic        slave_ready,
    output logic        ack,
    output logic        rd_bus,
    output logic        slave_valid,
    input  logic        master_ready,
    output logic        split,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [2:0]  dbg_state
);

    // Handshake: a bit moves on a rising edge only when its valid and the
    // opposite ready are both high; either side may hold its flag low to stall.

    localparam int WW = (SPLIT_DELAY < 1) ? 1 : $clog2(SPLIT_DELAY + 1);
    localparam logic [WW-1:0] SPLIT_MAX = WW'(SPLIT_DELAY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        IGNORE  = 3'd2,
        WDATA   = 3'd3,
        MEM_WR  = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6,
        RD_DATA = 3'd7
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [15:0]     addr;
    logic            mode_q;
    logic [3:0]      count;
    logic            id_match;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic [WW-1:0]   wait_cnt;
    logic            xfer;
    logic            rd_xfer;
    logic [3:0]      addr_idx;

    assign xfer      = master_valid & slave_ready;
    assign rd_xfer   = master_ready & slave_valid;
    assign addr_idx  = 4'd15 - count;
    assign mem_addr  = addr[11:0];
    assign mem_wdata = wdata;
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (xfer) next_state = ADDR;
            end
            ADDR: begin
                if (xfer) begin
                    if (count == 4'd5 && !id_match) begin
                        next_state = IGNORE;
                    end else if (count == 4'd15) begin
                        next_state = mode_q ? WDATA : RD_REQ;
                    end
                end
            end
            // Stay deaf until the master ends its burst for someone else
            IGNORE: begin
                if (!master_valid) next_state = IDLE;
            end
            WDATA: begin
                if (xfer && count == 4'd7) next_state = MEM_WR;
            end
            MEM_WR:  next_state = IDLE;
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: begin
                if (mem_rvalid) next_state = RD_DATA;
            end
            RD_DATA: begin
                if (rd_xfer && count == 4'd7) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        slave_ready = 1'b0;
        ack         = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        split       = 1'b0;
        mem_wen     = 1'b0;
        mem_ren     = 1'b0;
        case (state)
            IDLE, IGNORE, WDATA: slave_ready = 1'b1;
            ADDR: begin
                slave_ready = 1'b1;
                ack         = id_match & (count == 4'd4 || count == 4'd5);
            end
            MEM_WR: mem_wen = 1'b1;
            RD_REQ: mem_ren = 1'b1;
            // Data arriving on the cycle the wait limit is reached wins over split
            RD_WAIT: split = (wait_cnt >= SPLIT_MAX) & ~mem_rvalid;
            RD_DATA: begin
                slave_valid = 1'b1;
                rd_bus      = rdata[3'd7 - count[2:0]];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr     <= '0;
            mode_q   <= 1'b0;
            count    <= '0;
            id_match <= 1'b0;
            wdata    <= '0;
            rdata    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        addr[15] <= wr_bus;
                        mode_q   <= mode;
                        count    <= 4'd1;
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        addr[addr_idx] <= wr_bus;
                        // Device field completes with this bit; check it now
                        if (count == 4'd3) begin
                            id_match <= ({addr[15:13], wr_bus} == DEVICE_ID);
                        end
                        count <= count + 4'd1;
                    end
                end
                IGNORE: count <= '0;
                WDATA: begin
                    if (xfer) begin
                        wdata <= {wdata[6:0], wr_bus};
                        count <= (count == 4'd7) ? 4'd0 : count + 4'd1;
                    end
                end
                RD_REQ: wait_cnt <= '0;
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        rdata <= mem_rdata;
                        count <= '0;
                    end else if (wait_cnt != SPLIT_MAX) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                RD_DATA: begin
                    if (rd_xfer) begin
                        count <= (count == 4'd7) ? 4'd0 : count + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rstn)
        !(mem_wen && mem_ren));
    a_wen_single: assert property (@(posedge clk) disable iff (!rstn)
        mem_wen |=> !mem_wen);

endmodule

// File: tb/tb_bb_slave_port.sv
// Directed bench for bb_slave_port: serial writes, reads with and without split,
// address mismatch, stalled master and reset in mid-transaction.
module tb_bb_slave_port;

    logic        clk;
    logic        rstn;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        slave_ready;
    logic        ack;
    logic        rd_bus;
    logic        slave_valid;
    logic        master_ready;
    logic        split;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IGNORE = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_RD_REQ = 3'd5;

    bb_slave_port #(.DEVICE_ID(4'h1), .SPLIT_DELAY(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .ack          (ack),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .split        (split),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .dbg_state    (dbg_state)
    );

    // clock / strobe monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wen) wen_cnt++;
        if (mem_ren) ren_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input logic m, output logic ack_o);
        @(negedge clk);
        master_valid = 1'b1;
        wr_bus       = b;
        mode         = m;
        #1;
        ack_o = ack;
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        master_valid = 1'b0;
        wr_bus       = 1'b0;
        #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic m, input bit gap,
                             output logic [15:0] ack_v);
        logic ak;
        ack_v = '0;
        for (int i = 0; i < 16; i++) begin
            send_bit(a[15-i], m, ak);
            ack_v[i] = ak;
            if (gap) gap_cycle();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gap);
        logic ak;
        for (int i = 0; i < 8; i++) begin
            send_bit(d[7-i], 1'b1, ak);
            if (gap) gap_cycle();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [30:0] got;
        logic [30:0] exp;
        got = {slave_ready, ack, rd_bus, slave_valid, split, mem_wen, mem_ren,
               dbg_state, mem_addr, mem_wdata};
        exp = {1'b1, 6'b0, 3'd0, 12'h000, 8'h00};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: outputs got %h want %h", name, got, exp);
        end
    endtask

    task automatic do_write(input string name, input logic [15:0] a,
                            input logic [7:0] d, input bit gap);
        logic [15:0] ack_v;
        logic [15:0] exp_ack;
        int          wen0;
        wen0    = wen_cnt;
        exp_ack = (a[15:12] == 4'h1) ? 16'h0030 : 16'h0000;
        send_addr(a, 1'b1, gap, ack_v);
        total++;
        if (ack_v !== exp_ack) begin
            bad++;
            $display("FAIL %s_ack: got %h want %h", name, ack_v, exp_ack);
        end
        send_byte(d, gap);
        if (!gap) gap_cycle();
        total++;
        if ({mem_wen, dbg_state, mem_addr, mem_wdata} !== {1'b1, S_MEM_WR, a[11:0], d}) begin
            bad++;
            $display("FAIL %s_wr: wen/state/addr/data got %b/%0d/%h/%h want 1/4/%h/%h",
                     name, mem_wen, dbg_state, mem_addr, mem_wdata, a[11:0], d);
        end
        gap_cycle();
        total++;
        if ({mem_wen, dbg_state, slave_ready} !== {1'b0, S_IDLE, 1'b1}) begin
            bad++;
            $display("FAIL %s_end: wen/state/ready got %b/%0d/%b want 0/0/1",
                     name, mem_wen, dbg_state, slave_ready);
        end
        total++;
        if (wen_cnt != wen0 + 1) begin
            bad++;
            $display("FAIL %s_wen_count: got %0d want %0d", name, wen_cnt - wen0, 1);
        end
    endtask

    task automatic do_read(input string name, input logic [15:0] a, input logic [7:0] d,
                           input int delay, input bit toggle);
        logic [15:0] ack_v;
        logic [15:0] split_v;
        logic [15:0] exp_split;
        logic [7:0]  got;
        int          nbits;
        int          cycles;
        bit          sv_ok;
        logic        r;
        send_addr(a, 1'b0, 1'b0, ack_v);
        total++;
        if (ack_v !== 16'h0030) begin
            bad++;
            $display("FAIL %s_ack: got %h want %h", name, ack_v, 16'h0030);
        end
        gap_cycle();
        total++;
        if ({mem_ren, dbg_state, mem_addr} !== {1'b1, S_RD_REQ, a[11:0]}) begin
            bad++;
            $display("FAIL %s_ren: ren/state/addr got %b/%0d/%h want 1/5/%h",
                     name, mem_ren, dbg_state, mem_addr, a[11:0]);
        end
        split_v   = '0;
        exp_split = '0;
        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            mem_rvalid = (k == delay);
            mem_rdata  = (k == delay) ? d : 8'($urandom_range(0, 255));
            #1;
            split_v[k]   = split;
            exp_split[k] = (k - 1 >= 4) && (k != delay);
        end
        total++;
        if (split_v !== exp_split) begin
            bad++;
            $display("FAIL %s_split: got %b want %b", name, split_v, exp_split);
        end
        got    = '0;
        nbits  = 0;
        cycles = 0;
        sv_ok  = 1'b1;
        while (nbits < 8 && cycles < 40) begin
            @(negedge clk);
            mem_rvalid   = 1'b0;
            mem_rdata    = 8'hFF;
            r            = toggle ? (cycles % 2 == 0) : 1'b1;
            master_ready = r;
            #1;
            if (slave_valid !== 1'b1) sv_ok = 1'b0;
            if (r && slave_valid) begin
                got = {got[6:0], rd_bus};
                nbits++;
            end
            cycles++;
        end
        total++;
        if (nbits != 8 || !sv_ok) begin
            bad++;
            $display("FAIL %s_dataphase: bits %0d valid_ok %0d want 8 1", name, nbits, sv_ok);
        end
        total++;
        if (got !== d) begin
            bad++;
            $display("FAIL %s_rdata: got %h want %h", name, got, d);
        end
        @(negedge clk);
        master_ready = 1'b0;
        #1;
        total++;
        if ({dbg_state, slave_valid, rd_bus} !== {S_IDLE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s_end: state/valid/bus got %0d/%b/%b want 0/0/0",
                     name, dbg_state, slave_valid, rd_bus);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hFF;
        #1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        total++;
        if ({dbg_state, slave_valid, slave_ready} !== {S_IDLE, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL stray_rvalid: state/valid/ready got %0d/%b/%b want 0/0/1",
                     dbg_state, slave_valid, slave_ready);
        end
    endtask

    task automatic test_write();
        do_write("write", 16'h1234, 8'hA5, 1'b0);
        repeat (3) gap_cycle();
        total++;
        if (mem_addr !== 12'h234) begin
            bad++;
            $display("FAIL addr_hold: got %h want %h", mem_addr, 12'h234);
        end
    endtask

    task automatic test_ignore();
        logic [15:0] ack_v;
        int          wen0;
        int          ren0;
        wen0 = wen_cnt;
        ren0 = ren_cnt;
        send_addr(16'h2000, 1'b1, 1'b0, ack_v);
        total++;
        if (ack_v !== 16'h0000) begin
            bad++;
            $display("FAIL ignore_ack: got %h want %h", ack_v, 16'h0000);
        end
        total++;
        if ({dbg_state, slave_ready} !== {S_IGNORE, 1'b1}) begin
            bad++;
            $display("FAIL ignore_state: state/ready got %0d/%b want 2/1", dbg_state, slave_ready);
        end
        gap_cycle();
        gap_cycle();
        total++;
        if (dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL ignore_exit: state got %0d want 0", dbg_state);
        end
        total++;
        if (wen_cnt != wen0 || ren_cnt != ren0) begin
            bad++;
            $display("FAIL ignore_strobes: wen %0d ren %0d want 0 0", wen_cnt - wen0, ren_cnt - ren0);
        end
    endtask

    task automatic test_reset_abort();
        logic ak;
        int   wen0;
        int   ren0;
        for (int i = 0; i <= 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b1, ak);
        @(negedge clk);
        rstn         = 1'b0;
        master_valid = 1'b0;
        #1;
        check_reset_outputs("reset_abort");
        @(negedge clk);
        rstn = 1'b1;
        wen0 = wen_cnt;
        ren0 = ren_cnt;
        repeat (4) gap_cycle();
        total++;
        if (wen_cnt != wen0 || ren_cnt != ren0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL abort_quiet: wen %0d ren %0d state %0d want 0 0 0",
                     wen_cnt - wen0, ren_cnt - ren0, dbg_state);
        end
        do_write("after_abort", 16'h1F00, 8'hC3, 1'b0);
    endtask

    initial begin
        rstn         = 1'b0;
        mode         = 1'b0;
        wr_bus       = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        mem_rdata    = 8'h00;
        mem_rvalid   = 1'b0;

        test_reset();
        test_write();
        do_read("read_fast", 16'h1010, 8'h3C, 2, 1'b0);
        do_read("read_split", 16'h1ABC, 8'h96, 10, 1'b1);
        do_read("read_edge", 16'h1FFF, 8'h81, 5, 1'b0);
        test_ignore();
        do_write("write_toggle", 16'h1ABC, 8'h5A, 1'b1);
        test_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
